// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle logic/add/sub/compare, iterative MUL/DIV/REM.
// Optional divider datapath is enabled by defining ALU_MC_DIV_EN.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_zero_o,
  output logic             flag_ovf_o,
  output logic             flag_dz_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_ITER} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic            zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, done_q, done_d;
  logic            start_en_q;

  logic [WIDTH-1:0] sum_w, diff_w, sc_res;
  logic            sc_ovf, sc_dz, sc_long;
  kind_t           sc_kind;

  assign sum_w  = a_i + b_i;
  assign diff_w = a_i - b_i;

  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_dz   = 1'b0;
    sc_long = 1'b0;
    sc_kind = K_MUL;
    case (op_i)
      4'd0: sc_res = a_i & b_i;
      4'd1: sc_res = a_i | b_i;
      4'd2: begin
        sc_res = sum_w;
        sc_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd3: sc_res = '1;
      4'd4: sc_res = '0;
      4'd5: begin
        sc_long = 1'b1;
        sc_kind = K_MUL;
      end
      4'd6: begin
        sc_res = diff_w;
        sc_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd7: sc_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      4'd8, 4'd9: begin
`ifdef ALU_MC_DIV_EN
        if (b_i == '0) begin
          sc_dz  = 1'b1;
          sc_res = (op_i == 4'd8) ? '1 : a_i;
        end else begin
          sc_long = 1'b1;
          sc_kind = (op_i == 4'd8) ? K_DIV : K_REM;
        end
`else
        sc_dz = (b_i == '0);
`endif
      end
      4'd12: sc_res = ~(a_i | b_i);
      default: sc_res = '0;
    endcase
  end

  // MUL: {hi,lo} holds the partial product with the multiplier shifting out of lo.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

`ifdef ALU_MC_DIV_EN
  // DIV/REM: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];
`endif

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    if (kind_q != K_MUL) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && start_en_q) begin
          if (sc_long) begin
            state_d = S_ITER;
            kind_d  = sc_kind;
            count_d = '0;
            hi_d    = '0;
            lo_d    = (sc_kind == K_MUL) ? b_i : a_i;
            opnd_d  = (sc_kind == K_MUL) ? a_i : b_i;
          end else begin
            result_d = sc_res;
            zero_d   = (sc_res == '0);
            ovf_d    = sc_ovf;
            dz_d     = sc_dz;
            done_d   = 1'b1;
          end
        end
      end
      S_ITER: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d  = S_IDLE;
          count_d  = '0;
          result_d = (kind_q == K_REM) ? step_hi : step_lo;
          zero_d   = (((kind_q == K_REM) ? step_hi : step_lo) == '0);
          ovf_d    = (kind_q == K_MUL) && (step_hi != '0);
          dz_d     = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      kind_q     <= K_MUL;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      start_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      start_en_q <= 1'b1;
    end
  end

  assign busy_o      = (state_q == S_ITER);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign flag_zero_o = zero_q;
  assign flag_ovf_o  = ovf_q;
  assign flag_dz_o   = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, fz, fo, fd;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result),
    .flag_zero_o(fz), .flag_ovf_o(fo), .flag_dz_o(fd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] r, output logic ovf, output logic dz, output int lat);
    longint s;
    logic [63:0] p;
    r = '0; ovf = 1'b0; dz = 1'b0; lat = 1;
    case (mop)
      4'd0: r = ma & mb;
      4'd1: r = ma | mb;
      4'd2: begin
        s = longint'($signed(ma)) + longint'($signed(mb));
        r = ma + mb;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: r = '1;
      4'd5: begin
        p = {32'b0, ma} * {32'b0, mb};
        r = p[31:0];
        ovf = (p[63:32] != 0);
        lat = W;
      end
      4'd6: begin
        s = longint'($signed(ma)) - longint'($signed(mb));
        r = ma - mb;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: r = (ma < mb) ? 1 : 0;
      4'd8, 4'd9: begin
        dz = (mb == 0);
`ifdef ALU_MC_DIV_EN
        if (mb == 0) r = (mop == 4'd8) ? '1 : ma;
        else begin
          r = (mop == 4'd8) ? ma / mb : ma % mb;
          lat = W;
        end
`endif
      end
      4'd12: r = ~(ma | mb);
      default: r = '0;
    endcase
  endfunction

  // Issue one op, wait for its completion (bounded) and check timing, result and flags.
  task automatic run_op(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb, input string tag);
    logic [W-1:0] er;
    logic eo, ed, overlap;
    int lat, cyc;
    model(mop, ma, mb, er, eo, ed, lat);
    @(negedge clk);
    start = 1'b1; op = mop; a = ma; b = mb;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    overlap = 1'b0;
    cyc = 0;
    if (lat > 1) begin
      chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
      while (!done && cyc < 60) begin
        @(posedge clk); #1;
        cyc++;
        if (busy && done) overlap = 1'b1;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'(W));
      chk({tag, "_ovl"}, {63'b0, overlap}, 64'd0);
    end
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_res"}, {32'b0, result}, {32'b0, er});
    chk({tag, "_flags"}, {61'b0, fz, fo, fd}, {61'b0, (er == 0), eo, ed});
  endtask

  task automatic hold_check(input logic [W-1:0] er, input string tag);
    @(posedge clk); #1;
    chk({tag, "_dlow"}, {63'b0, done}, 64'd0);
    chk({tag, "_hold"}, {32'b0, result}, {32'b0, er});
  endtask

  initial begin
    int dones, cyc;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {28'b0, busy, done, fz, fo, result, fd}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(4'd2, 32'h7FFFFFFF, 32'd1, "add_ovf");
    hold_check(32'h80000000, "add_ovf");
    run_op(4'd6, 32'h80000000, 32'd1, "sub_ovf");
    run_op(4'd12, 32'h0F0F0000, 32'h00F0000F, "nor");
    run_op(4'd3, 32'd0, 32'd0, "ones");
    run_op(4'd11, 32'h1234, 32'h5678, "undef");

    // Back-to-back SLT, start held high across two edges.
    @(negedge clk);
    start = 1'b1; op = 4'd7; a = 32'd5; b = 32'd3;
    @(posedge clk); #1;
    a = 32'd3; b = 32'd5;
    chk("slt1_res", {32'b0, result}, 64'd0);
    chk("slt1_fz", {62'b0, done, fz}, 64'd3);
    @(posedge clk); #1;
    start = 1'b0;
    chk("slt2_res", {32'b0, result}, 64'd1);
    chk("slt2_fz", {62'b0, done, fz}, 64'd2);
    hold_check(32'd1, "slt2");

    run_op(4'd5, 32'd3, 32'd5, "mul15");
    hold_check(32'd15, "mul15");
    run_op(4'd5, 32'h10000, 32'h10000, "mul_ovf");

    // Start while busy must be ignored: exactly one completion with the MUL result.
    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_res", {32'b0, result}, 64'd63);

    run_op(4'd8, 32'd100, 32'd7, "div");
    run_op(4'd9, 32'd100, 32'd7, "rem");
    run_op(4'd8, 32'd100, 32'd0, "div_dz");
    run_op(4'd9, 32'd100, 32'd0, "rem_dz");

    // Reset mid-iteration aborts without a done pulse.
    run_op(4'd3, 32'd0, 32'd0, "pre_rst");
    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out", {28'b0, busy, done, fz, fo, result, fd}, 64'd0);
    dones = 0;
    cyc = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("abort_quiet", 64'(dones), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; op = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rel_ignore", {31'b0, done, result}, 64'd0);
    run_op(4'd0, 32'hF0, 32'h3C, "and_post");

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h7FFFFFFF;
        2: rb = 32'h80000000;
        3: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      run_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised integer ALU for the EX stage of the pipelined MIPS core. It executes logic, add/sub and compare ops in one cycle. Multiply, divide and remainder run iteratively over WIDTH cycles behind a start/busy/done handshake, so the pipeline stalls only on long ops. It also reports zero, overflow and divide-by-zero flags.

## Interface
- WIDTH, 32: operand/result width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  4  opcode, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  iterative op in progress.
- done  out  1  one-cycle pulse; result/flags updated this cycle.
- result  out  WIDTH  registered result, held until next completion.
- flag_zero  out  1  result==0, registered with result.
- flag_ovf  out  1  overflow; see Operation.
- flag_dz  out  1  divide/remainder by zero.

## Operation
- Opcodes (all unsigned unless stated):
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 all ones
  - 4 zero
  - 5 MUL (low WIDTH bits)
  - 6 SUB (a-b)
  - 7 SLT unsigned (result 1 if a<b, else 0; never holds a stale value)
  - 8 DIV (quotient)
  - 9 REM (remainder)
  - 12 NOR
  - all others: result 0.
- flag_ovf:
  - ADD/SUB: signed two's-complement overflow.
  - MUL: set when the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - All other ops: 0.
- flag_dz: set only for op 8/9 with b==0. In that case result = all ones for DIV and a for REM, and completion takes a single cycle.
- FSM states:
  - IDLE: accepts start.
    - Single-cycle op or divide-by-zero: result written, done=1, stay in IDLE.
    - MUL, or DIV/REM with b≠0: latch operands, clear accumulator, count=0 → ITER.
  - ITER: one shift-add (MUL) or restoring shift-subtract (DIV/REM) step per cycle. At count==WIDTH-1, write result/flags, pulse done → IDLE.
- start while busy=1 is ignored; inputs changing during ITER have no effect.
- Reset: state IDLE, count 0, busy=0, done=0, result=0, flag_zero=0, flag_ovf=0, flag_dz=0.

## Timing
- Start accepted at edge k:
  - Single-cycle op: result/flags/done valid after edge k; done low after edge k+1 unless another op completes.
  - Iterative op: busy=1 after edge k through edge k+WIDTH-1. At edge k+WIDTH, busy=0, done=1, result valid. Latency is WIDTH cycles.
- done and busy are never high together.
- Back-to-back: start may be asserted in the cycle done is high (busy=0), giving full throughput for single-cycle ops.
- result, flag_zero, flag_ovf and flag_dz change only on a done edge or on reset.
- Reset asserted mid-ITER aborts the op immediately: no done pulse, outputs take reset values.
- Release of rst_n is synchronised by the top level; start is treated as 0 on the first edge after release.

## Configuration
- ALU_MC_DIV_EN defined: ops 8/9 are implemented as above.
- Not defined: the divider datapath is removed. Ops 8/9 complete in one cycle with result 0, flag_dz = (b==0), flag_ovf=0, and never enter ITER.

## Test plan
- WIDTH=32, op 2, a=0x7FFFFFFF, b=1 → after 1 cycle: result=0x80000000, flag_ovf=1, flag_zero=0, done pulse 1 cycle.
- op 7, a=5, b=3, then a=3, b=5 back-to-back → results 0 then 1 on consecutive cycles; flag_zero 1 then 0.
- op 5, a=3, b=5 → busy for 32 cycles, done at cycle 32, result=15, flag_ovf=0. Repeat with a=b=0x10000 → result=0, flag_ovf=1, flag_zero=1.
- op 8, a=100, b=7 → result=14 after 32 cycles. Then op 9 with the same operands → result=2. During the op 8 run, a start with op 2 is ignored (no extra done).
- op 8, b=0 → 1-cycle completion, result=0xFFFFFFFF, flag_dz=1. With ALU_MC_DIV_EN undefined, op 8, a=100, b=7 → result=0 after 1 cycle.
- Start op 5, assert rst_n=0 at cycle 10 → busy=0 and all outputs 0 immediately, no done pulse; after release, op 0 with a=0xF0, b=0x3C → result=0x30.
